// File: rtl/wishbone_master_queued.sv
// Queued Wishbone classic master: commands are buffered in a FIFO and issued as
// single-beat cycles with rty retry, per-attempt timeout and status-tagged responses.
module wishbone_master_queued #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_we,
    input  logic [ADDR_W-1:0]            cmd_adr,
    input  logic [DATA_W/8-1:0]          cmd_sel,
    input  logic [DATA_W-1:0]            cmd_dat,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_dat,
    output logic [1:0]                   rsp_status,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         busy,
    output logic [ADDR_W-1:0]            adr,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout,
    output logic                         cyc,
    output logic                         stb,
    output logic [DATA_W/8-1:0]          sel,
    output logic                         we,
    input  logic                         ack,
    input  logic                         err,
    input  logic                         rty
);

    localparam int SEL_W = DATA_W / 8;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 1 + ADDR_W + SEL_W + DATA_W;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;
    localparam logic [1:0] ST_RTY = 2'd2;
    localparam logic [1:0] ST_TMO = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [ENT_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   count_next_s;
    logic [ENT_W-1:0]   head_s;
    logic [RTY_W-1:0]   retry_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               push_s;
    logic               launch_s;
    logic               reissue_s;
    logic               drop_s;
    logic               rsp_load_s;
    logic               retry_inc_s;
    logic               tmo_inc_s;
    logic [1:0]         status_s;
    logic [DATA_W-1:0]  rdat_s;

    assign push_s = cmd_valid && cmd_ready;
    assign head_s = mem_r[rd_ptr_r];

    // Next-state and per-cycle control strobes for the bus sequencer
    always_comb begin
        state_next_s = state_r;
        launch_s     = 1'b0;
        reissue_s    = 1'b0;
        drop_s       = 1'b0;
        rsp_load_s   = 1'b0;
        retry_inc_s  = 1'b0;
        tmo_inc_s    = 1'b0;
        status_s     = ST_OK;
        rdat_s       = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if ((fifo_level != LVL_ZERO) && (!rsp_valid || rsp_ready)) begin
                    launch_s     = 1'b1;
                    state_next_s = BUS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUS: begin
                // err wins over ack, ack over rty
                if (err) begin
                    drop_s       = 1'b1;
                    rsp_load_s   = 1'b1;
                    status_s     = ST_ERR;
                    state_next_s = IDLE;
                end else if (ack) begin
                    drop_s       = 1'b1;
                    rsp_load_s   = 1'b1;
                    status_s     = ST_OK;
                    rdat_s       = we ? {DATA_W{1'b0}} : din;
                    state_next_s = IDLE;
                end else if (rty) begin
                    drop_s = 1'b1;
                    if (retry_r < RTY_MAX) begin
                        retry_inc_s  = 1'b1;
                        state_next_s = BACKOFF;
                    end else begin
                        rsp_load_s   = 1'b1;
                        status_s     = ST_RTY;
                        state_next_s = IDLE;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    drop_s       = 1'b1;
                    rsp_load_s   = 1'b1;
                    status_s     = ST_TMO;
                    state_next_s = IDLE;
                end else begin
                    tmo_inc_s = 1'b1;
                end
            end
            BACKOFF: begin
                reissue_s    = 1'b1;
                state_next_s = BUS;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FIFO occupancy after this edge
    always_comb begin
        count_next_s = fifo_level;
        if (push_s && !launch_s) begin
            count_next_s = fifo_level + LVL_ONE;
        end else if (launch_s && !push_s) begin
            count_next_s = fifo_level - LVL_ONE;
        end else begin
            count_next_s = fifo_level;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command storage; occupancy is tracked by the level counter so no reset needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_we, cmd_adr, cmd_sel, cmd_dat};
        end
    end

    // FIFO pointers, level, ready and busy flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_level <= LVL_ZERO;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (launch_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fifo_level <= count_next_s;
            cmd_ready  <= (count_next_s != LVL_FULL);
            busy       <= (state_next_s != IDLE) || (count_next_s != LVL_ZERO);
        end
    end

    // Wishbone request signals plus retry and timeout counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc     <= 1'b0;
            stb     <= 1'b0;
            we      <= 1'b0;
            adr     <= {ADDR_W{1'b0}};
            sel     <= {SEL_W{1'b0}};
            dout    <= {DATA_W{1'b0}};
            retry_r <= {RTY_W{1'b0}};
            tmo_r   <= {TMO_W{1'b0}};
        end else if (launch_s) begin
            {we, adr, sel, dout} <= head_s;
            cyc     <= 1'b1;
            stb     <= 1'b1;
            retry_r <= {RTY_W{1'b0}};
            tmo_r   <= {TMO_W{1'b0}};
        end else if (reissue_s) begin
            // Same request fields are still held from the launch
            cyc   <= 1'b1;
            stb   <= 1'b1;
            tmo_r <= {TMO_W{1'b0}};
        end else if (drop_s) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            if (retry_inc_s) begin
                retry_r <= retry_r + RTY_W'(1);
            end
        end else if (tmo_inc_s) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end

    // Response holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_dat    <= {DATA_W{1'b0}};
            rsp_status <= ST_OK;
        end else if (rsp_load_s) begin
            rsp_valid  <= 1'b1;
            rsp_dat    <= rdat_s;
            rsp_status <= status_s;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_dat    <= {DATA_W{1'b0}};
            rsp_status <= ST_OK;
        end
    end

endmodule

// File: tb/tb_wishbone_master_queued.sv
// Directed bench for wishbone_master_queued: a scripted slave plus a queue model of
// accepted commands and expected responses, checked every cycle on the falling edge.
module tb_wishbone_master_queued;

    localparam int DEPTH  = 4;
    localparam int MAXR   = 3;
    localparam int TMO    = 255;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_SIL  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'h0, cmd_dat = 32'h0;
    logic [3:0]  cmd_sel = 4'h0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [2:0]  fifo_level;
    logic        busy;
    logic [31:0] adr, din = 32'h0, dout;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

    wishbone_master_queued #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MAX_RETRY(MAXR), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status), .fifo_level(fifo_level), .busy(busy),
        .adr(adr), .din(din), .dout(dout), .cyc(cyc), .stb(stb), .sel(sel),
        .we(we), .ack(ack), .err(err), .rty(rty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          wt;
        int          nrty;
        int          kind;
        logic [31:0] din;
    } cmd_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  status;
    } rsp_t;

    cmd_t pend_q[$];
    rsp_t exp_q[$];

    int n_tests = 0, n_fail = 0;
    int att_cnt = 0, rty_done = 0, cur_len = 0, last_len = 0, pulse_cnt = 0, rsp_cnt = 0;
    int max_level = 0;
    bit pop_pending = 0, in_attempt = 0, need_low = 0, backoff_pend = 0;
    bit reissue_next = 0, expect_rsp = 0, prev_cyc = 0, saw_full_stall = 0;
    logic [31:0] last_rdat = 32'h0;
    logic [1:0]  last_rstat = 2'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic end_attempt(input bit final_term);
        in_attempt = 0;
        need_low   = 1;
        if (final_term) begin
            pop_pending = 1;
            expect_rsp  = 1;
            rty_done    = 0;
        end else begin
            backoff_pend = 1;
        end
    endtask

    // Falling-edge model: check outputs against the queues, then drive the slave reply
    task automatic monitor();
        cmd_t c;
        logic t_ack, t_err, t_rty;
        t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0;
        if (rst) begin
            pend_q.delete(); exp_q.delete();
            pop_pending = 0; in_attempt = 0; need_low = 0; backoff_pend = 0;
            reissue_next = 0; expect_rsp = 0; prev_cyc = 0; cur_len = 0; rty_done = 0;
        end else begin
            if (pop_pending) begin
                c = pend_q.pop_front();
                pop_pending = 0;
            end
            chk("busy", busy, pend_q.size() != 0);
            chk("cyc_eq_stb", stb, cyc);
            if (expect_rsp) chk("rsp_latency", rsp_valid, 1);
            expect_rsp = 0;
            if (need_low) begin
                chk("cyc_drop", cyc, 0);
                need_low = 0;
                reissue_next = backoff_pend;
                backoff_pend = 0;
            end else if (reissue_next) begin
                chk("backoff_reissue", cyc, 1);
                reissue_next = 0;
            end else if (in_attempt) begin
                chk("cyc_hold", cyc, 1);
            end
            if (cyc) cur_len++;
            else if (prev_cyc) begin
                last_len = cur_len; pulse_cnt++; cur_len = 0;
            end
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (int'(fifo_level) == DEPTH && !cmd_ready) saw_full_stall = 1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    chk("rsp_dat", rsp_dat, exp_q[0].dat);
                    chk("rsp_status", rsp_status, exp_q[0].status);
                    if (rsp_ready) begin
                        last_rdat = rsp_dat; last_rstat = rsp_status; rsp_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (cyc) begin
                if (!prev_cyc) att_cnt = 0;
                if (pend_q.size() == 0) chk("spurious_cyc", cyc, 0);
                else begin
                    c = pend_q[0];
                    in_attempt = 1;
                    chk("adr", adr, c.adr);
                    chk("we", we, c.we);
                    chk("sel", sel, c.sel);
                    if (c.we) chk("dout", dout, c.dat);
                    if (rty_done < c.nrty) begin
                        if (att_cnt == c.wt) begin
                            t_rty = 1'b1; rty_done++;
                            end_attempt(rty_done > MAXR);
                        end
                    end else if (c.kind == K_SIL) begin
                        if (att_cnt == TMO - 1) end_attempt(1);
                    end else if (att_cnt == c.wt) begin
                        t_ack = (c.kind == K_ACK) || (c.kind == K_BOTH);
                        t_err = (c.kind == K_ERR) || (c.kind == K_BOTH);
                        din   = c.din;
                        end_attempt(1);
                    end
                    att_cnt++;
                end
            end
            prev_cyc = cyc;
        end
        ack = t_ack; err = t_err; rty = t_rty;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int wt, input int nrty, input int kind, input logic [31:0] dv);
        cmd_t c;
        rsp_t r;
        int guard;
        c.we = w; c.adr = a; c.sel = 4'hF; c.dat = d;
        c.wt = wt; c.nrty = nrty; c.kind = kind; c.din = dv;
        if (nrty > MAXR)          r.status = 2'd2;
        else if (kind == K_SIL)   r.status = 2'd3;
        else if (kind == K_ACK)   r.status = 2'd0;
        else                      r.status = 2'd1;
        r.dat = (r.status == 2'd0 && !w) ? dv : 32'h0;
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_sel = 4'hF; cmd_dat = d;
        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            tick();
            guard++;
        end
        chk("cmd_accept", cmd_ready, 1);
        if (cmd_ready) begin
            tick();
            pend_q.push_back(c);
            exp_q.push_back(r);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && guard < 3000) begin
            tick();
            guard++;
        end
        chk("drain", pend_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_cyc", cyc, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", cmd_ready, 1);

        // Single write, two wait states
        send(1'b1, 32'h10, 32'hA5A5_0001, 2, 0, K_ACK, 32'h0);
        chk("t1_cyc_not_yet", cyc, 0);
        chk("t1_level", fifo_level, 1);
        tick();
        chk("t1_cyc", cyc, 1);
        chk("t1_we", we, 1);
        chk("t1_adr", adr, 32'h10);
        chk("t1_dout", dout, 32'hA5A5_0001);
        chk("t1_level_popped", fifo_level, 0);
        drain();
        chk("t1_len", last_len, 3);
        chk("t1_status", last_rstat, 0);
        chk("t1_dat", last_rdat, 0);

        // Queued reads filling the FIFO
        max_level = 0; saw_full_stall = 0; rsp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 32'(i * 4), 32'h0, 3, 0, K_ACK, 32'(8'h11 * (i + 1)));
        end
        drain();
        chk("t2_max_level", max_level, DEPTH);
        chk("t2_full_stall", saw_full_stall, 1);
        chk("t2_rsp_cnt", rsp_cnt, 5);
        chk("t2_last_dat", last_rdat, 32'h55);

        // Two rty then ack
        pulse_cnt = 0;
        send(1'b0, 32'h20, 32'h0, 0, 2, K_ACK, 32'hBEEF);
        drain();
        chk("t3_pulses", pulse_cnt, 3);
        chk("t3_status", last_rstat, 0);
        chk("t3_dat", last_rdat, 32'hBEEF);

        // Retries exhausted
        pulse_cnt = 0;
        send(1'b0, 32'h24, 32'h0, 1, 4, K_ACK, 32'h1234);
        drain();
        chk("t3x_pulses", pulse_cnt, 4);
        chk("t3x_status", last_rstat, 2);
        chk("t3x_dat", last_rdat, 0);

        // Silent slave timeout, then simultaneous err and ack
        send(1'b1, 32'h30, 32'hDEAD, 0, 0, K_SIL, 32'h0);
        drain();
        chk("t4_len", last_len, 255);
        chk("t4_status", last_rstat, 3);
        send(1'b0, 32'h34, 32'h0, 1, 0, K_BOTH, 32'h77);
        drain();
        chk("t4e_status", last_rstat, 1);
        chk("t4e_dat", last_rdat, 0);

        // Response backpressure
        rsp_ready = 1'b0; rsp_cnt = 0; pulse_cnt = 0;
        send(1'b1, 32'h40, 32'h1, 1, 0, K_ACK, 32'h0);
        send(1'b1, 32'h44, 32'h2, 1, 0, K_ACK, 32'h0);
        repeat (10) tick();
        chk("t5_pulses", pulse_cnt, 1);
        chk("t5_held", rsp_valid, 1);
        chk("t5_level", fifo_level, 1);
        chk("t5_idle", cyc, 0);
        rsp_ready = 1'b1;
        tick();
        chk("t5_launch", cyc, 1);
        chk("t5_rsp_cleared", rsp_valid, 0);
        chk("t5_rsp_cnt1", rsp_cnt, 1);
        drain();
        chk("t5_rsp_cnt2", rsp_cnt, 2);

        // Reset in the middle of a bus cycle with two queued
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'h50 + 32'(i * 4), 32'h0, 20, 0, K_ACK, 32'hAA);
        end
        chk("t6_in_bus", cyc, 1);
        chk("t6_queued", fifo_level, 2);
        rst = 1'b1;
        tick();
        chk("t6_cyc", cyc, 0);
        chk("t6_stb", stb, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        rst = 1'b0; rsp_cnt = 0; pulse_cnt = 0;
        repeat (30) tick();
        chk("t6_no_cycles", pulse_cnt, 0);
        chk("t6_no_rsp", rsp_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
